// File: rtl/rs_age_pkg.sv
// rs_age_pkg: shared types for the age-ordered reservation station.
//   dispatch_pipeline_data : op as offered by dispatch
//   rs_data                : op as issued to the functional unit
//   rs_entry_t             : one issue-queue slot
//   rob_younger()          : ROB-relative age compare that survives index wrap
package rs_age_pkg;

   localparam int PREG_W = 7;   // physical register tag width
   localparam int ROB_W  = 4;   // ROB index width
   localparam int IMM_W  = 32;  // immediate width
   localparam int FU_W   = 3;   // functional-unit id width

   typedef struct packed {
      logic [PREG_W-1:0] prd;
      logic [PREG_W-1:0] pr1;
      logic [PREG_W-1:0] pr2;
      logic              pr1_ready;
      logic              pr2_ready;
      logic [IMM_W-1:0]  imm;
      logic [ROB_W-1:0]  rob_index;
      logic [6:0]        Opcode;
      logic [2:0]        func3;
      logic [6:0]        func7;
   } dispatch_pipeline_data;

   typedef struct packed {
      logic [PREG_W-1:0] pd;
      logic [PREG_W-1:0] ps1;
      logic [PREG_W-1:0] ps2;
      logic              ps1_ready;
      logic              ps2_ready;
      logic [IMM_W-1:0]  imm;
      logic [ROB_W-1:0]  rob_index;
      logic [6:0]        Opcode;
      logic [2:0]        func3;
      logic [6:0]        func7;
      logic [FU_W-1:0]   fu;
   } rs_data;

   typedef struct packed {
      logic              valid;
      logic [PREG_W-1:0] pd;
      logic [PREG_W-1:0] ps1;
      logic [PREG_W-1:0] ps2;
      logic              ps1_ready;
      logic              ps2_ready;
      logic [IMM_W-1:0]  imm;
      logic [ROB_W-1:0]  rob_index;
      logic [6:0]        Opcode;
      logic [2:0]        func3;
      logic [6:0]        func7;
   } rs_entry_t;

   // True when idx is strictly younger than ref_idx. Both are rebased to the
   // ROB head so the comparison stays correct across index wrap-around.
   function automatic logic rob_younger(input logic [ROB_W-1:0] idx,
                                        input logic [ROB_W-1:0] ref_idx,
                                        input logic [ROB_W-1:0] head);
      logic [ROB_W-1:0] d_idx;
      logic [ROB_W-1:0] d_ref;
      d_idx = idx - head;
      d_ref = ref_idx - head;
      return (d_idx > d_ref);
   endfunction

endpackage

// File: rtl/rs_age_if.sv
// rs_age_if: bundle of dispatch, wakeup, flush and issue signals of rs_age.
//   Dispatch : valid_in/ready_in handshake carrying instr; an op transfers on
//              a rising edge where valid_in && ready_in. nr_valid/nr_reg
//              announce the destination tag of that transfer.
//   Wakeup   : wake_reg/wake_valid, N_WAKE tag broadcast channels.
//   Flush    : flush, flush_partial, flush_rob_idx, rob_head.
//   Issue    : fu_rdy from the FU; valid_out pulses one cycle with data_out.
// modport slave is the reservation station, modport master its environment.
interface rs_age_if #(parameter int N_WAKE = 3);
   import rs_age_pkg::*;

   logic                             valid_in;
   logic                             ready_in;
   dispatch_pipeline_data            instr;
   logic [PREG_W-1:0]                nr_reg;
   logic                             nr_valid;
   logic                             fu_rdy;
   logic                             valid_out;
   rs_data                           data_out;
   logic [N_WAKE-1:0][PREG_W-1:0]    wake_reg;
   logic [N_WAKE-1:0]                wake_valid;
   logic                             flush;
   logic                             flush_partial;
   logic [ROB_W-1:0]                 flush_rob_idx;
   logic [ROB_W-1:0]                 rob_head;

   modport master (
      output valid_in, instr, fu_rdy, wake_reg, wake_valid,
             flush, flush_partial, flush_rob_idx, rob_head,
      input  ready_in, nr_reg, nr_valid, valid_out, data_out
   );

   modport slave (
      input  valid_in, instr, fu_rdy, wake_reg, wake_valid,
             flush, flush_partial, flush_rob_idx, rob_head,
      output ready_in, nr_reg, nr_valid, valid_out, data_out
   );

endinterface

// File: rtl/rs_age_picker.sv
// rs_age_picker: age matrix and oldest-first grant for DEPTH slots.
//   clk, reset : clock, asynchronous active-high reset
//   i_alloc    : one-hot slot being filled this edge (becomes youngest)
//   i_free     : slots being vacated this edge
//   i_elig     : slots that may be granted this cycle
//   o_grant    : one-hot oldest eligible slot
//   o_found    : some slot is granted
module rs_age_picker #(
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DEPTH-1:0] i_alloc,
   input  logic [DEPTH-1:0] i_free,
   input  logic [DEPTH-1:0] i_elig,
   output logic [DEPTH-1:0] o_grant,
   output logic             o_found
);

   // r_older[i][j] = 1 means slot i holds an older op than slot j.
   logic [DEPTH-1:0][DEPTH-1:0] r_older;
   logic [DEPTH-1:0]            w_blocked;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_older <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
               if (i == j)
                  r_older[i][j] <= 1'b0;
               else if (i_alloc[i] || i_free[i])
                  r_older[i][j] <= 1'b0;   // new or vacated slot is older than nobody
               else if (i_alloc[j])
                  r_older[i][j] <= 1'b1;   // everyone left is older than the newcomer
               else if (i_free[j])
                  r_older[i][j] <= 1'b0;
            end
         end
      end
   end

   // A slot wins when no other eligible slot is older than it.
   always_comb begin
      w_blocked = '0;
      for (int i = 0; i < DEPTH; i++) begin
         for (int j = 0; j < DEPTH; j++) begin
            if ((i != j) && i_elig[j] && r_older[j][i])
               w_blocked[i] = 1'b1;
         end
      end
   end

   assign o_grant = i_elig & ~w_blocked;
   assign o_found = |o_grant;

endmodule

// File: rtl/rs_age.sv
// rs_age: DEPTH-entry issue queue between dispatch and one functional unit.
//   clk   : clock, all state changes on the rising edge
//   reset : asynchronous active-high clear
//   bus   : rs_age_if.slave -- dispatch handshake (valid_in/ready_in/instr),
//           not-ready announce (nr_valid/nr_reg), N_WAKE wakeup channels,
//           flush controls, and issue output (fu_rdy/valid_out/data_out).
// Ops wait until both sources are ready, then the oldest ready op issues
// when fu_rdy is high. Wakeups seen during enqueue are captured directly.
module rs_age
   import rs_age_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int N_WAKE = 3,
   parameter int FU_ID  = 0
) (
   input  logic     clk,
   input  logic     reset,
   rs_age_if.slave  bus
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   rs_entry_t        r_entries [DEPTH];
   logic [CNT_W-1:0] r_count;
   logic             r_valid_out;
   rs_data           r_data_out;

   logic [N_WAKE-1:0][PREG_W-1:0] w_wake_reg;
   logic [N_WAKE-1:0]             w_wake_valid;
   logic [DEPTH-1:0]              w_valid;
   logic [DEPTH-1:0]              w_kill;
   logic [DEPTH-1:0]              w_elig;
   logic [DEPTH-1:0]              w_free_slot;
   logic [DEPTH-1:0]              w_alloc;
   logic [DEPTH-1:0]              w_grant;
   logic [DEPTH-1:0]              w_issue_oh;
   logic [DEPTH-1:0]              w_free;
   logic [CNT_W-1:0]              w_kill_cnt;
   logic                          w_found;
   logic                          w_slot_seen;
   logic                          w_full_flush;
   logic                          w_enq_kill;
   logic                          w_enq;
   logic                          w_issue;
   logic                          w_ready_in;
   rs_entry_t                     w_new;
   rs_data                        w_sel;

   function automatic logic wake_hit(input logic [PREG_W-1:0]             tag,
                                     input logic [N_WAKE-1:0][PREG_W-1:0] regs,
                                     input logic [N_WAKE-1:0]             vld);
      logic hit;
      hit = 1'b0;
      for (int c = 0; c < N_WAKE; c++) begin
         if (vld[c] && (regs[c] == tag))
            hit = 1'b1;
      end
      return hit;
   endfunction

   assign w_wake_reg   = bus.wake_reg;
   assign w_wake_valid = bus.wake_valid;
   assign w_full_flush = bus.flush & ~bus.flush_partial;
   // Credit comes from the registered count only; a same-cycle issue does
   // not make room for a same-cycle enqueue.
   assign w_ready_in   = (r_count < CNT_W'(DEPTH));

   // Per-slot kill and select eligibility. Eligibility deliberately ignores
   // the kill: a killed winner suppresses issue for the cycle rather than
   // letting a younger survivor slip through.
   always_comb begin
      w_kill_cnt = '0;
      for (int e = 0; e < DEPTH; e++) begin
         w_valid[e] = r_entries[e].valid;
         w_kill[e]  = r_entries[e].valid & bus.flush &
                      (~bus.flush_partial |
                       rob_younger(r_entries[e].rob_index, bus.flush_rob_idx, bus.rob_head));
         w_elig[e]  = r_entries[e].valid & r_entries[e].ps1_ready &
                      r_entries[e].ps2_ready & bus.fu_rdy;
         w_kill_cnt = w_kill_cnt + CNT_W'(w_kill[e]);
      end
   end

   // Enqueue: lowest-numbered free slot, dropped if the flush covers it.
   assign w_enq_kill = bus.flush &
                       (~bus.flush_partial |
                        rob_younger(bus.instr.rob_index, bus.flush_rob_idx, bus.rob_head));
   assign w_enq      = bus.valid_in & w_ready_in & ~w_enq_kill;

   always_comb begin
      w_free_slot = '0;
      w_slot_seen = 1'b0;
      for (int e = 0; e < DEPTH; e++) begin
         if (!w_valid[e] && !w_slot_seen) begin
            w_free_slot[e] = 1'b1;
            w_slot_seen    = 1'b1;
         end
      end
   end

   assign w_alloc = w_enq ? w_free_slot : '0;

   // Source is ready if dispatch says so, it is the zero register, or a
   // wakeup for it is on the broadcast channels right now.
   always_comb begin
      w_new           = '0;
      w_new.valid     = 1'b1;
      w_new.pd        = bus.instr.prd;
      w_new.ps1       = bus.instr.pr1;
      w_new.ps2       = bus.instr.pr2;
      w_new.ps1_ready = bus.instr.pr1_ready | (bus.instr.pr1 == '0) |
                        wake_hit(bus.instr.pr1, w_wake_reg, w_wake_valid);
      w_new.ps2_ready = bus.instr.pr2_ready | (bus.instr.pr2 == '0) |
                        wake_hit(bus.instr.pr2, w_wake_reg, w_wake_valid);
      w_new.imm       = bus.instr.imm;
      w_new.rob_index = bus.instr.rob_index;
      w_new.Opcode    = bus.instr.Opcode;
      w_new.func3     = bus.instr.func3;
      w_new.func7     = bus.instr.func7;
   end

   rs_age_picker #(.DEPTH(DEPTH)) u_picker (
      .clk     (clk),
      .reset   (reset),
      .i_alloc (w_alloc),
      .i_free  (w_free),
      .i_elig  (w_elig),
      .o_grant (w_grant),
      .o_found (w_found)
   );

   assign w_issue    = w_found & ~|(w_grant & w_kill);
   assign w_issue_oh = w_issue ? w_grant : '0;
   assign w_free     = w_issue_oh | w_kill;

   // One-hot mux of the granted slot into the issue format.
   always_comb begin
      w_sel = '0;
      for (int e = 0; e < DEPTH; e++) begin
         if (w_grant[e]) begin
            w_sel.pd        = r_entries[e].pd;
            w_sel.ps1       = r_entries[e].ps1;
            w_sel.ps2       = r_entries[e].ps2;
            w_sel.imm       = r_entries[e].imm;
            w_sel.rob_index = r_entries[e].rob_index;
            w_sel.Opcode    = r_entries[e].Opcode;
            w_sel.func3     = r_entries[e].func3;
            w_sel.func7     = r_entries[e].func7;
         end
      end
      w_sel.ps1_ready = 1'b1;
      w_sel.ps2_ready = 1'b1;
      w_sel.fu        = FU_W'(FU_ID);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int e = 0; e < DEPTH; e++)
            r_entries[e] <= '0;
         r_count     <= '0;
         r_valid_out <= 1'b0;
         r_data_out  <= '0;
      end else begin
         for (int e = 0; e < DEPTH; e++) begin
            if (w_free[e]) begin
               r_entries[e].valid <= 1'b0;
            end else if (w_alloc[e]) begin
               r_entries[e] <= w_new;
            end else if (w_valid[e]) begin
               if (wake_hit(r_entries[e].ps1, w_wake_reg, w_wake_valid))
                  r_entries[e].ps1_ready <= 1'b1;
               if (wake_hit(r_entries[e].ps2, w_wake_reg, w_wake_valid))
                  r_entries[e].ps2_ready <= 1'b1;
            end
         end
         // Issue and kill are disjoint, so this never under/overflows.
         r_count     <= r_count + CNT_W'(w_enq) - CNT_W'(w_issue) - w_kill_cnt;
         r_valid_out <= w_issue;
         if (w_issue)
            r_data_out <= w_sel;
      end
   end

   assign bus.ready_in  = w_ready_in;
   assign bus.nr_reg    = bus.instr.prd;
   assign bus.nr_valid  = bus.valid_in & w_ready_in & ~reset & ~w_full_flush &
                          (bus.instr.prd != '0);
   assign bus.valid_out = r_valid_out;
   assign bus.data_out  = r_data_out;

endmodule
